// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//   ID-stage branch/jump resolution controller sitting right after the 32-bit
//   equality comparator. Decodes BEQ/BNE/J, computes the redirect target,
//   registers the decision and presents a one-cycle redirect (PC select +
//   IF/ID flush) the cycle after resolution. While branch operands are not
//   yet forwarded it stalls IF/ID and runs a saturating wait counter whose
//   expiry raises a sticky timeout flag.
//
// Parameters
//   DATA_W    PC / operand width (>= 28 for the J-format target)
//   MAX_WAIT  hazard-wait cycles before O_HAZ_TIMEOUT asserts (1..15)
//
// Ports
//   I_CLK, I_RST_N    clock (rising edge), asynchronous active-low reset
//   I_BR_VALID        conditional branch in ID
//   I_BR_NE           0 = BEQ, 1 = BNE
//   I_JUMP            unconditional J in ID (wins over I_BR_VALID)
//   I_COM_IGUAL       comparator equal flag (same cycle)
//   I_OPND_HAZARD     branch operands not yet available
//   I_PC_PLUS4        PC+4 of the instruction in ID
//   I_BR_OFFSET       sign-extended 16-bit immediate
//   I_JUMP_IDX        J-format 26-bit index
//   O_PC_SEL          IF loads O_PC_TARGET on the next edge
//   O_PC_TARGET       redirect address (holds last value outside redirect)
//   O_IFID_FLUSH      zero the IF/ID register
//   O_STALL           freeze PC and IF/ID (combinational)
//   O_HAZ_TIMEOUT     sticky hazard-wait timeout
//
// Optional feature (macro BRCTRL_STATS_EN)
//   Adds O_BR_TAKEN_CNT / O_BR_NTAKEN_CNT: saturating 16-bit counts of
//   resolved conditional branches (jumps and aborted waits not counted).
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_BR_VALID,
  input  logic              I_BR_NE,
  input  logic              I_JUMP,
  input  logic              I_COM_IGUAL,
  input  logic              I_OPND_HAZARD,
  input  logic [DATA_W-1:0] I_PC_PLUS4,
  input  logic [DATA_W-1:0] I_BR_OFFSET,
  input  logic [25:0]       I_JUMP_IDX,
  output logic              O_PC_SEL,
  output logic [DATA_W-1:0] O_PC_TARGET,
  output logic              O_IFID_FLUSH,
  output logic              O_STALL,
  output logic              O_HAZ_TIMEOUT
`ifdef BRCTRL_STATS_EN
  ,
  output logic [15:0]       O_BR_TAKEN_CNT,
  output logic [15:0]       O_BR_NTAKEN_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REDIR
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] WCNT_SAT   = 4'hF;

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              tout_q, tout_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;

  logic [DATA_W-1:0] br_tgt;
  logic [DATA_W-1:0] jmp_tgt;
  logic              br_taken;
  logic              resolve;
  logic              stall;

  assign br_tgt   = I_PC_PLUS4 + (I_BR_OFFSET << 2);
  assign br_taken = I_BR_NE ^ I_COM_IGUAL;

  // J target keeps the top PC+4 bits above the 28-bit region
  always_comb begin
    jmp_tgt        = I_PC_PLUS4;
    jmp_tgt[27:0]  = {I_JUMP_IDX, 2'b00};
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tout_d  = tout_q;
    tgt_d   = tgt_q;
    stall   = 1'b0;
    resolve = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_JUMP) begin
          state_d = ST_REDIR;
          tgt_d   = jmp_tgt;
        end else if (I_BR_VALID) begin
          if (I_OPND_HAZARD) begin
            state_d = ST_WAIT;
            stall   = 1'b1;
            wcnt_d  = 4'd1;
            if (4'd1 >= MAX_WAIT_C) tout_d = 1'b1;
          end else begin
            resolve = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (!I_BR_VALID) begin
          // branch squashed from outside while waiting: drop it silently
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (I_OPND_HAZARD) begin
          stall  = 1'b1;
          wcnt_d = (wcnt_q == WCNT_SAT) ? WCNT_SAT : wcnt_q + 4'd1;
          if (wcnt_d >= MAX_WAIT_C) tout_d = 1'b1;
        end else begin
          resolve = 1'b1;
          wcnt_d  = '0;
        end
      end

      ST_REDIR: begin
        // ID holds the squashed slot; its inputs are ignored
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // shared resolution for IDLE (no hazard) and WAIT (hazard released)
    if (resolve) begin
      if (br_taken) begin
        state_d = ST_REDIR;
        tgt_d   = br_tgt;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      tout_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tout_q  <= tout_d;
      tgt_q   <= tgt_d;
    end
  end

  assign O_PC_SEL      = (state_q == ST_REDIR);
  assign O_IFID_FLUSH  = (state_q == ST_REDIR);
  assign O_PC_TARGET   = tgt_q;
  assign O_STALL       = stall;
  assign O_HAZ_TIMEOUT = tout_q;

`ifdef BRCTRL_STATS_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] ncnt_q, ncnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    ncnt_d = ncnt_q;
    if (resolve) begin
      if (br_taken) begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + 16'd1;
      end else begin
        if (ncnt_q != '1) ncnt_d = ncnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      tcnt_q <= '0;
      ncnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      ncnt_q <= ncnt_d;
    end
  end

  assign O_BR_TAKEN_CNT  = tcnt_q;
  assign O_BR_NTAKEN_CNT = ncnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Scoreboard bench for branch_resolve_ctrl. Each transaction computes its
//   expected redirect target from the instruction semantics and pushes it to
//   a queue; an independent negedge monitor pops and compares whenever the
//   DUT presents a redirect. Stall / timeout / reset behaviour is checked
//   per cycle from a cycle-count model of the hazard wait.
//   Define BRCTRL_STATS_EN to also check the branch statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  localparam int unsigned MAX_WAIT = 4;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_BR_VALID;
  logic        I_BR_NE;
  logic        I_JUMP;
  logic        I_COM_IGUAL;
  logic        I_OPND_HAZARD;
  logic [31:0] I_PC_PLUS4;
  logic [31:0] I_BR_OFFSET;
  logic [25:0] I_JUMP_IDX;
  logic        O_PC_SEL;
  logic [31:0] O_PC_TARGET;
  logic        O_IFID_FLUSH;
  logic        O_STALL;
  logic        O_HAZ_TIMEOUT;
`ifdef BRCTRL_STATS_EN
  logic [15:0] O_BR_TAKEN_CNT;
  logic [15:0] O_BR_NTAKEN_CNT;
`endif

  branch_resolve_ctrl #(
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .I_CLK         (I_CLK),
    .I_RST_N       (I_RST_N),
    .I_BR_VALID    (I_BR_VALID),
    .I_BR_NE       (I_BR_NE),
    .I_JUMP        (I_JUMP),
    .I_COM_IGUAL   (I_COM_IGUAL),
    .I_OPND_HAZARD (I_OPND_HAZARD),
    .I_PC_PLUS4    (I_PC_PLUS4),
    .I_BR_OFFSET   (I_BR_OFFSET),
    .I_JUMP_IDX    (I_JUMP_IDX),
    .O_PC_SEL      (O_PC_SEL),
    .O_PC_TARGET   (O_PC_TARGET),
    .O_IFID_FLUSH  (O_IFID_FLUSH),
    .O_STALL       (O_STALL),
    .O_HAZ_TIMEOUT (O_HAZ_TIMEOUT)
`ifdef BRCTRL_STATS_EN
    ,
    .O_BR_TAKEN_CNT  (O_BR_TAKEN_CNT),
    .O_BR_NTAKEN_CNT (O_BR_NTAKEN_CNT)
`endif
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_tgt;
  bit          tout_exp;
  int          cnt_t, cnt_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every presented redirect must match the oldest expected target
  always @(negedge I_CLK) begin
    if (I_RST_N && (O_PC_SEL || O_IFID_FLUSH)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_redirect", 32'(O_PC_SEL), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("redir_pc_sel", 32'(O_PC_SEL), 32'd1);
        chk("redir_flush", 32'(O_IFID_FLUSH), 32'd1);
        chk("redir_target", O_PC_TARGET, e);
      end
    end
  end

  task automatic drv(input logic j, input logic bv, input logic ne, input logic eq,
                     input logic hz, input logic [31:0] pc, input logic [31:0] off,
                     input logic [25:0] idx);
    @(posedge I_CLK);
    #1;
    I_JUMP        = j;
    I_BR_VALID    = bv;
    I_BR_NE       = ne;
    I_COM_IGUAL   = eq;
    I_OPND_HAZARD = hz;
    I_PC_PLUS4    = pc;
    I_BR_OFFSET   = off;
    I_JUMP_IDX    = idx;
  endtask

  task automatic drv_idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
  endtask

  task automatic zero_inputs();
    I_JUMP = 1'b0; I_BR_VALID = 1'b0; I_BR_NE = 1'b0; I_COM_IGUAL = 1'b0;
    I_OPND_HAZARD = 1'b0; I_PC_PLUS4 = '0; I_BR_OFFSET = '0; I_JUMP_IDX = '0;
  endtask

  task automatic chk_stats(input string nm);
`ifdef BRCTRL_STATS_EN
    chk({nm, "_taken_cnt"}, 32'(O_BR_TAKEN_CNT), 32'(cnt_t));
    chk({nm, "_ntaken_cnt"}, 32'(O_BR_NTAKEN_CNT), 32'(cnt_n));
`else
    if (nm.len() == 0) $display("stats disabled");
`endif
  endtask

  // asynchronous reset asserted mid-cycle; everything must clear at once
  task automatic mid_reset(input string nm);
    I_RST_N = 1'b0;
    zero_inputs();
    exp_q.delete();
    tout_exp = 1'b0;
    last_tgt = '0;
    cnt_t    = 0;
    cnt_n    = 0;
    #1;
    chk({nm, "_pc_sel"}, 32'(O_PC_SEL), 32'd0);
    chk({nm, "_flush"}, 32'(O_IFID_FLUSH), 32'd0);
    chk({nm, "_target"}, O_PC_TARGET, 32'd0);
    chk({nm, "_timeout"}, 32'(O_HAZ_TIMEOUT), 32'd0);
    chk({nm, "_stall"}, 32'(O_STALL), 32'd0);
    chk_stats(nm);
    @(negedge I_CLK);
    I_RST_N = 1'b1;
  endtask

  // one instruction: optional hazard wait, optional abort, then resolution
  task automatic do_txn(input bit is_j, input bit also_br, input bit ne, input bit eq,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic [25:0] idx, input int unsigned haz, input bit abort);
    bit          redir;
    logic [31:0] tgt;
    redir = 1'b0;
    if (is_j) begin
      drv(1'b1, also_br, ne, eq, 1'($urandom_range(0, 1)), pc, off, idx);
      tgt = (pc & 32'hF000_0000) | (32'(idx) * 32'd4);
      exp_q.push_back(tgt);
      last_tgt = tgt;
      redir    = 1'b1;
      @(negedge I_CLK);
      chk("jump_stall", 32'(O_STALL), 32'd0);
    end else begin
      for (int unsigned i = 0; i < haz; i++) begin
        drv(1'b0, 1'b1, ne, eq, 1'b1, pc, off, idx);
        @(negedge I_CLK);
        chk("haz_stall", 32'(O_STALL), 32'd1);
        chk("haz_timeout", 32'(O_HAZ_TIMEOUT), 32'(tout_exp));
        if (i + 1 >= MAX_WAIT) tout_exp = 1'b1;
      end
      if (abort) begin
        drv(1'b0, 1'b0, ne, eq, 1'($urandom_range(0, 1)), pc, off, idx);
        @(negedge I_CLK);
        chk("abort_stall", 32'(O_STALL), 32'd0);
        chk("abort_timeout", 32'(O_HAZ_TIMEOUT), 32'(tout_exp));
      end else begin
        drv(1'b0, 1'b1, ne, eq, 1'b0, pc, off, idx);
        if (ne != eq) begin
          tgt = pc + off * 32'd4;
          exp_q.push_back(tgt);
          last_tgt = tgt;
          redir    = 1'b1;
          if (cnt_t < 65535) cnt_t++;
        end else begin
          if (cnt_n < 65535) cnt_n++;
        end
        @(negedge I_CLK);
        chk("resolve_stall", 32'(O_STALL), 32'd0);
        chk("resolve_timeout", 32'(O_HAZ_TIMEOUT), 32'(tout_exp));
      end
    end
    // redirect cycle carries junk from the squashed slot
    if (redir)
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
          26'($urandom));
    else
      drv_idle();
    @(negedge I_CLK);
    chk("post_stall", 32'(O_STALL), 32'd0);
    drv_idle();
    @(negedge I_CLK);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("idle_pc_sel", 32'(O_PC_SEL), 32'd0);
    chk("target_hold", O_PC_TARGET, last_tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] off16;
    I_RST_N = 1'b0;
    zero_inputs();
    tout_exp = 1'b0;
    last_tgt = '0;
    cnt_t    = 0;
    cnt_n    = 0;
    #2;
    chk("rst_pc_sel", 32'(O_PC_SEL), 32'd0);
    chk("rst_flush", 32'(O_IFID_FLUSH), 32'd0);
    chk("rst_target", O_PC_TARGET, 32'd0);
    chk("rst_timeout", 32'(O_HAZ_TIMEOUT), 32'd0);
    chk("rst_stall", 32'(O_STALL), 32'd0);
    chk_stats("rst");
    @(negedge I_CLK);
    I_RST_N = 1'b1;

    // BEQ taken, BNE/BEQ not taken, negative offset
    do_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0004, 26'd0, 0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0004, 26'd0, 0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0004, 26'd0, 0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 26'd0, 0, 1'b0);
    // short hazard, no timeout
    do_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_0010, 26'd0, 2, 1'b0);
    chk_stats("stats_3_2");
    // long hazard: timeout rises and sticks
    do_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_0020, 26'd0, 5, 1'b0);
    chk("timeout_sticky", 32'(O_HAZ_TIMEOUT), 32'd1);
    // jumps, including J+BEQ illegal combination
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'hA000_0004, 32'h0, 26'h000_0040, 0, 1'b0);
    do_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0004, 32'h4, 26'h000_0040, 0, 1'b0);

    // reset during WAIT
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h4, 26'd0);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h4, 26'd0);
    @(negedge I_CLK);
    chk("wait_stall_pre_rst", 32'(O_STALL), 32'd1);
    mid_reset("rst_wait");

    // reset during REDIR
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0004, 26'd0);
    @(posedge I_CLK);
    #1;
    chk("redir_pre_rst", 32'(O_PC_SEL), 32'd1);
    #1;
    mid_reset("rst_redir");

    // abort while waiting
    do_txn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0008, 26'd0, 3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      int unsigned h;
      bit          ab;
      bit          j;
      h     = $urandom_range(0, 6);
      ab    = (h > 0) && ($urandom_range(0, 4) == 0);
      j     = ($urandom_range(0, 4) == 0);
      off16 = 16'($urandom);
      do_txn(j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, {{16{off16[15]}}, off16}, 26'($urandom), j ? 0 : h, j ? 1'b0 : ab);
    end
    chk_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
